qr_stream_core: RTL

- Parametrised stream front-end for the QR CORDIC engine; successor to the fixed 8-column single-shot wrapper.
- Reads NUM_COL input beats per frame from the input stream FIFO and feeds them to the engine.
- Collects the engine's NUM_COL result beats into an internal buffer and drains them to the output stream FIFO.
- Fully honours isif_empty_n / osif_full_n backpressure, pads short frames, and flags framing errors.

---
 rtl/qr_stream_pkg.sv | 20 ++
 rtl/qr_stream_obuf.sv | 50 +++++
 rtl/qr_stream_core.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/qr_stream_pkg.sv
// Shared types and defaults for the QR CORDIC stream front-end.
// Holds the controller state encoding and the engine word-width helper.
package qr_stream_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    PAD     = 2'd2,
    COLLECT = 2'd3
  } state_t;

  localparam int DEF_DATA_LENGTH = 13;
  localparam int DEF_NUM_LANE    = 4;
  localparam int DEF_NUM_COL     = 8;

  function automatic int eng_width(input int data_length, input int num_lane);
    return data_length * num_lane;
  endfunction

endpackage

// File: rtl/qr_stream_obuf.sv
// Output-side result buffer: synchronous FIFO with show-ahead head word.
// Push into a full buffer or pop from an empty one is ignored.
module qr_stream_obuf #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  // Pointers wrap explicitly so non-power-of-two depths work.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= (wr_ptr_reg == AW'(DEPTH - 1)) ? '0 : wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= (rd_ptr_reg == AW'(DEPTH - 1)) ? '0 : rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

  assign head  = mem[rd_ptr_reg];
  assign empty = (count_reg == '0);
  assign full  = (count_reg == CW'(DEPTH));
  assign count = count_reg;

endmodule

// File: rtl/qr_stream_core.sv
// Stream front-end for the QR CORDIC engine: frames input beats, pads short frames, buffers results.
// Optional macro QR_STREAM_BYPASS_EN: frames whose first beat has user=1 skip the engine.
module qr_stream_core
  import qr_stream_pkg::*;
#(
  parameter int TBITS       = 64,
  parameter int TBYTE       = 8,
  parameter int DATA_LENGTH = DEF_DATA_LENGTH,
  parameter int NUM_LANE    = DEF_NUM_LANE,
  parameter int NUM_COL     = DEF_NUM_COL
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [TBITS-1:0]                isif_data_dout,
  input  logic [TBYTE-1:0]                isif_strb_dout,
  input  logic                            isif_last_dout,
  input  logic                            isif_user_dout,
  input  logic                            isif_empty_n,
  output logic                            isif_read,
  output logic [TBITS-1:0]                osif_data_din,
  output logic [TBYTE-1:0]                osif_strb_din,
  output logic                            osif_last_din,
  output logic                            osif_user_din,
  input  logic                            osif_full_n,
  output logic                            osif_write,
  output logic                            eng_valid,
  output logic [DATA_LENGTH*NUM_LANE-1:0] eng_in,
  input  logic                            eng_out_valid,
  input  logic [DATA_LENGTH*NUM_LANE-1:0] eng_out,
  input  logic                            err_clr,
  output logic                            frame_err,
  output logic                            busy
);

  localparam int EW   = eng_width(DATA_LENGTH, NUM_LANE);
  localparam int CNTW = $clog2(NUM_COL + 1);
`ifdef QR_STREAM_BYPASS_EN
  localparam int BW = TBITS + 2;  // {last, user, data}
`else
  localparam int BW = TBITS;
`endif
  localparam logic [CNTW-1:0] LAST_IDX = CNTW'(NUM_COL - 1);
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(NUM_COL);

  state_t          state_reg, state_next;
  logic [CNTW-1:0] in_cnt_reg, in_cnt_next;
  logic [CNTW-1:0] out_cnt_reg, out_cnt_next;
  logic [CNTW-1:0] wr_cnt_reg, wr_cnt_next;
  logic [CNTW-1:0] len_reg, len_next;
  logic            bypass_reg, bypass_next;
  logic            err_reg, err_set;
  logic            byp_beat;

  logic            buf_push, buf_empty, buf_full;
  logic [BW-1:0]   buf_din, buf_head;
  logic [CNTW-1:0] buf_count;
  logic            unused_ok;

  qr_stream_obuf #(
    .WIDTH(BW),
    .DEPTH(NUM_COL)
  ) u_obuf (
    .clk      (clk),
    .rst      (rst),
    .push     (buf_push),
    .push_data(buf_din),
    .pop      (osif_write),
    .head     (buf_head),
    .empty    (buf_empty),
    .full     (buf_full),
    .count    (buf_count)
  );

  always_comb begin
    state_next    = state_reg;
    in_cnt_next   = in_cnt_reg;
    out_cnt_next  = out_cnt_reg;
    wr_cnt_next   = wr_cnt_reg;
    len_next      = len_reg;
    bypass_next   = bypass_reg;
    err_set       = 1'b0;
    isif_read     = 1'b0;
    eng_valid     = 1'b0;
    eng_in        = '0;
    buf_push      = 1'b0;
    buf_din       = '0;
    byp_beat      = 1'b0;
    osif_write    = !buf_empty && osif_full_n;
    osif_data_din = buf_empty ? '0 : buf_head[TBITS-1:0];
`ifdef QR_STREAM_BYPASS_EN
    osif_user_din = !buf_empty && buf_head[TBITS];
    osif_last_din = osif_write && (bypass_reg ? buf_head[TBITS+1] : (wr_cnt_reg == LAST_IDX));
`else
    osif_user_din = 1'b0;
    osif_last_din = osif_write && (wr_cnt_reg == LAST_IDX);
`endif

    case (state_reg)
      IDLE: if (isif_empty_n) state_next = READ;
      READ: begin
`ifdef QR_STREAM_BYPASS_EN
        // The first beat's user flag decides the route of the whole frame.
        byp_beat = bypass_reg || (in_cnt_reg == '0 && isif_user_dout);
        if (byp_beat) begin
          isif_read = isif_empty_n && !buf_full;
          if (isif_read) begin
            buf_push    = 1'b1;
            buf_din     = {isif_last_dout, 1'b1, isif_data_dout};
            bypass_next = 1'b1;
            in_cnt_next = in_cnt_reg + CNTW'(1);
            if (isif_last_dout || in_cnt_reg == LAST_IDX) begin
              state_next  = COLLECT;
              len_next    = in_cnt_reg + CNTW'(1);
              in_cnt_next = '0;
              err_set     = !(isif_last_dout && in_cnt_reg == LAST_IDX);
            end
          end
        end
`endif
        if (!byp_beat) begin
          isif_read = isif_empty_n;
          if (isif_empty_n) begin
            eng_valid   = 1'b1;
            eng_in      = isif_data_dout[EW-1:0];
            in_cnt_next = in_cnt_reg + CNTW'(1);
            if (in_cnt_reg == LAST_IDX) begin
              state_next  = COLLECT;
              in_cnt_next = '0;
              err_set     = !isif_last_dout;
            end else if (isif_last_dout) begin
              state_next = PAD;
              err_set    = 1'b1;
            end
          end
        end
      end
      PAD: begin
        eng_valid   = 1'b1;
        in_cnt_next = in_cnt_reg + CNTW'(1);
        if (in_cnt_reg == LAST_IDX) begin
          state_next  = COLLECT;
          in_cnt_next = '0;
        end
      end
      COLLECT: ;
      default: state_next = IDLE;
    endcase

    // Result beats are only expected while collecting a non-bypassed frame.
    if (eng_out_valid) begin
      if (state_reg == COLLECT && !bypass_reg && out_cnt_reg < FULL_CNT) begin
        buf_push          = 1'b1;
        buf_din           = '0;
        buf_din[EW-1:0]   = eng_out;
        out_cnt_next      = out_cnt_reg + CNTW'(1);
      end else begin
        err_set = 1'b1;
      end
    end

    if (osif_write) wr_cnt_next = wr_cnt_reg + CNTW'(1);

    if (state_reg == COLLECT && osif_write && wr_cnt_reg == len_reg - CNTW'(1)) begin
      state_next   = IDLE;
      in_cnt_next  = '0;
      out_cnt_next = '0;
      wr_cnt_next  = '0;
      len_next     = FULL_CNT;
      bypass_next  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      in_cnt_reg  <= '0;
      out_cnt_reg <= '0;
      wr_cnt_reg  <= '0;
      len_reg     <= FULL_CNT;
      bypass_reg  <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      in_cnt_reg  <= in_cnt_next;
      out_cnt_reg <= out_cnt_next;
      wr_cnt_reg  <= wr_cnt_next;
      len_reg     <= len_next;
      bypass_reg  <= bypass_next;
      if (err_set)      err_reg <= 1'b1;
      else if (err_clr) err_reg <= 1'b0;
    end
  end

  assign frame_err     = err_reg;
  assign busy          = (state_reg != IDLE);
  assign osif_strb_din = '1;
  assign unused_ok     = ^{isif_strb_dout, isif_data_dout, isif_user_dout, buf_full, buf_count};

endmodule
